// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo-N display counter.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP   = 2'b10,
        MODE_SET  = 2'b11
    } mode_t;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of one counter digit. The master drives the mode,
// tick and adjust inputs; the counter (slave) returns value and strobes.
interface mod_counter_if #(
    parameter int WIDTH = 6
);
    import mod_counter_pkg::*;

    logic             tick;
    mode_t            mode;
    logic             clear;
    logic             inc_in;
    logic             dec_in;
    logic [WIDTH-1:0] value;
    logic             carry_out;
    logic             at_zero;

    modport master (
        output tick, mode, clear, inc_in, dec_in,
        input  value, carry_out, at_zero
    );

    modport slave (
        input  tick, mode, clear, inc_in, dec_in,
        output value, carry_out, at_zero
    );

endinterface

// File: rtl/mod_counter_edge_sync.sv
// Synchroniser for an asynchronous level plus rising-edge detector.
// rise is a one-cycle strobe in the clk domain.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("edge_sync: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the async level through the chain; hist holds the previous synced value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter digit with same-cycle carry/borrow for cascading
// and a SET mode driven by synchronised inc/dec pulses.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int MODULUS     = 60,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    mod_counter_if.slave bus
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_zero_q;
    logic             inc_rise;
    logic             dec_rise;
    logic             at_max;
    logic             at_min;

    // Edge detectors run in every mode so a level already high on entry to SET
    // never looks like a fresh press.
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.inc_in),
        .rise  (inc_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dec_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.dec_in),
        .rise  (dec_rise)
    );

    assign at_max = (value_q == MAX_VAL);
    assign at_min = (value_q == '0);

    // Next-value mux: tick-driven count in UP/DOWN, edge-driven adjust in SET.
    always_comb begin
        value_d = value_q;
        case (bus.mode)
            MODE_DOWN: begin
                if (bus.tick) value_d = at_min ? MAX_VAL : value_q - WIDTH'(1);
            end
            MODE_UP: begin
                if (bus.tick) value_d = at_max ? '0 : value_q + WIDTH'(1);
            end
            MODE_SET: begin
                // Simultaneous inc and dec cancel out.
                if (inc_rise && !dec_rise)      value_d = at_max ? '0 : value_q + WIDTH'(1);
                else if (dec_rise && !inc_rise) value_d = at_min ? MAX_VAL : value_q - WIDTH'(1);
            end
            default: value_d = value_q;
        endcase
    end

    // Value and at_zero register together so at_zero always matches value.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            value_q   <= '0;
            at_zero_q <= 1'b1;
        end else begin
            value_q   <= value_d;
            at_zero_q <= (value_d == '0);
        end
    end

    // Carry is combinational so the next digit steps on the same edge as this one wraps.
    assign bus.carry_out = bus.tick & ~bus.clear & ~reset &
                           (((bus.mode == MODE_DOWN) & at_min) |
                            ((bus.mode == MODE_UP)   & at_max));

    assign bus.value   = value_q;
    assign bus.at_zero = at_zero_q;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter for the VGA timer/clock display path. It counts ticks up or down with wrap-around and a same-cycle carry/borrow output for cascading digits (seconds → minutes → hours). It also has a set mode in which debounced user pulses adjust the value. The two adjust inputs are asynchronous; they are synchronised and edge-detected inside the block, so the whole block runs on `clk`.

## Interface
Parameters:
- `WIDTH`, 6: value width in bits.
- `MODULUS`, 60: count range is 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2**WIDTH; elaboration error otherwise.
- `SYNC_STAGES`, 2: synchroniser depth for `inc_in`/`dec_in`. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  count enable, one-cycle strobe; ignored in HOLD and SET.
- `mode`  in  2  00 HOLD, 01 DOWN, 10 UP, 11 SET.
- `clear`  in  1  synchronous clear of value, any mode.
- `inc_in`  in  1  asynchronous level; each rising edge adds 1 in SET.
- `dec_in`  in  1  asynchronous level; each rising edge subtracts 1 in SET.
- `value`  out  WIDTH  current count, registered.
- `carry_out`  out  1  combinational wrap strobe for the next stage's `tick`.
- `at_zero`  out  1  registered; high when `value`==0.

## Operation
- Priority per cycle: `reset` > `clear` > mode action.
- **`reset`**:
  - `value`=0, `at_zero`=1.
  - All synchroniser and edge-detect flops cleared to 0.
- **`clear`**:
  - `value`=0.
  - Synchronisers keep running.
  - Pending edges are discarded.
- **HOLD**: `value` unchanged; `tick` ignored.
- **DOWN**, on `tick`:
  - `value`==0 → MODULUS-1.
  - Otherwise `value`-1.
- **UP**, on `tick`:
  - `value`==MODULUS-1 → 0.
  - Otherwise `value`+1.
- **SET**:
  - Rising edge of synchronised `inc_in` → +1, wrapping MODULUS-1 → 0.
  - Rising edge of synchronised `dec_in` → -1, wrapping 0 → MODULUS-1.
  - Both edges in the same cycle → no change.
  - `tick` ignored.
- **`carry_out`**:
  - = `tick` & ((DOWN & `value`==0) | (UP & `value`==MODULUS-1)) & ~`clear` & ~`reset`.
  - Never asserted in SET or HOLD.
- **Edge detectors** run in every mode, so an `inc_in` held high across a switch into SET produces no edge. Adjust edges that occur outside SET are dropped.
- **Arithmetic**: WIDTH bits, compared against MODULUS-1. `value` must never leave 0..MODULUS-1.
- **Mode change**: takes effect on the same edge that samples the new `mode`. No state is kept per mode.

## Timing
- **`tick` → `value`**: `tick` sampled at edge k; `value` updates after edge k (1-cycle latency).
- **`carry_out`**: asserted combinationally in the cycle before the wrap edge. A cascaded stage therefore updates on the same edge k, with no added latency per stage.
- **`at_zero`**: registered together with `value`, so it is never stale relative to `value`.
- **Adjust latency**: `inc_in` rising before edge 1 → synchronised high after edge SYNC_STAGES → `value` changes after edge SYNC_STAGES+1.
- **Adjust minimum pulse**: high ≥1 clk period, and low ≥1 clk period between pulses. Pulses shorter than one period may be lost.
- **Reset mid-count** wins over `tick` in the same cycle; no `carry_out`.
- **`clear` and `tick` together** → `value`=0, `carry_out`=0.

## Structure
- Package `mod_counter_pkg`: `mode_t` enum (MODE_HOLD, MODE_DOWN, MODE_UP, MODE_SET).
- Sub-module `edge_sync` (param SYNC_STAGES):
  - Synchroniser chain plus one history flop.
  - Output `rise` = sync & ~hist.
  - Synchronous reset to 0.
  - Instantiated twice, for `inc_in` and `dec_in`.
- Top level holds the next-value mux, wrap compare and `carry_out` logic.

## Test plan
Defaults: WIDTH=6, MODULUS=60, SYNC_STAGES=2.
1. Reset, then DOWN with `tick` every cycle: `value` 0→59→58…; `carry_out`=1 only in cycles where `value`=0 and `tick`=1.
2. UP, 61 ticks from 0: `value` reaches 59, then 0, then 1; exactly one `carry_out` pulse. Chain two instances (second stage `tick` = first stage `carry_out`): after 60 ticks the second stage reads 1, updating on the same edge.
3. SET, one `inc_in` pulse at `value`=59: `value`=0 exactly SYNC_STAGES+1 edges after the rise; `carry_out` stays 0. A `dec_in` pulse then returns `value` to 59.
4. SET, `inc_in` and `dec_in` rising in the same cycle: `value` unchanged. `inc_in` held high while switching HOLD→SET: no increment.
5. `value`=37 in UP with `tick`=1, assert `clear` → `value`=0, `at_zero`=1, `carry_out`=0. Assert `reset` together with `tick` at `value`=59 → `value`=0, no `carry_out`.
6. HOLD, 100 ticks and 5 `inc_in` pulses → `value` constant. Repeat scenarios 1–2 with MODULUS=24, WIDTH=5: wrap at 23.
